main_control_fsm: RTL
=====================

# main_control_fsm

Multi-cycle main control unit for the RV32I datapath. It sequences each instruction through fetch, decode, execute, memory and writeback. It is the producer of the `aluop`/`func_op`/`lui` encoding consumed by the ALU control decoder, and it drives all datapath enables and muxes. It sits between the instruction register/memory handshake and the ALU control decoder.

## Interface
- No parameters; opcode and state constants come from the shared package.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `instr` in 32: current instruction register contents, valid from DECODE onward.
- `mem_ready` in 1: memory handshake; the access completes in any cycle where it is high while a request is asserted.
- `alu_zero` in 1: ALU zero flag, used in BRANCH.
- `aluop` out 2: 00 add/LUI, 01 sub, 10 R-type, 11 I-type.
- `func_op` out 4: `{instr[30], instr[14:12]}` in EXEC states, else 0000.
- `lui` out 1: high only in EXEC_LUI.
- `mem_read`, `mem_write` out 1 each: memory request; held until `mem_ready`.
- `ir_write`, `pc_write`, `reg_write` out 1 each: register enables.
- `alu_src_a` out 1: 0 = PC, 1 = rs1.
- `alu_src_b` out 2: 00 = rs2, 01 = immediate, 10 = constant 4.
- `wb_sel` out 2: 00 = ALU result, 01 = memory data, 10 = PC+4.
- `pc_src` out 1: 0 = PC+4, 1 = ALU target.
- `illegal` out 1: sticky illegal-instruction flag.

## Operation
- Moore FSM. All outputs decode from the state register; outputs not listed for a state are 0.
- States and behaviour:
  - FETCH: `mem_read`=1. When `mem_ready` is high, assert `ir_write`=1, `pc_write`=1 (PC+4), then go to DECODE.
  - DECODE: dispatch on `instr[6:0]`:
    - 0110011 → EXEC_R.
    - 0010011 → EXEC_I.
    - 0000011 or 0100011 → MEM_ADDR.
    - 1100011 → BRANCH.
    - 0110111 → EXEC_LUI.
    - 1101111 or 1100111 → JUMP (only with the macro; see Configuration).
    - Anything else → TRAP.
  - EXEC_R: `aluop`=10, `alu_src_a`=1, `alu_src_b`=00, then WB_ALU.
  - EXEC_I: `aluop`=11, `alu_src_a`=1, `alu_src_b`=01, then WB_ALU.
  - EXEC_LUI: `aluop`=00, `lui`=1, `alu_src_b`=01, then WB_ALU.
  - MEM_ADDR: `aluop`=00, `alu_src_a`=1, `alu_src_b`=01. Load → MEM_RD; store → MEM_WR.
  - MEM_RD: `mem_read`=1; wait for `mem_ready`, then WB_MEM.
  - MEM_WR: `mem_write`=1; wait for `mem_ready`, then FETCH.
  - WB_ALU: `reg_write`=1, `wb_sel`=00, then FETCH.
  - WB_MEM: `reg_write`=1, `wb_sel`=01, then FETCH.
  - BRANCH: `aluop`=01, `alu_src_a`=1, `alu_src_b`=00.
    - `pc_write`=1 with `pc_src`=1 when (funct3=000 and `alu_zero`) or (funct3=001 and not `alu_zero`).
    - Other funct3 → TRAP.
    - Otherwise → FETCH.
  - TRAP: sets `illegal`. The FSM stays in TRAP until `rst`.
- R-type funct7 values other than 0000000/0100000, or funct7=0100000 with funct3 ∉ {000,101}, → TRAP from DECODE.

## Timing
- Reset: state=FETCH, `illegal`=0.
- Reset-cycle outputs: `mem_read`=1, all other outputs 0.
- Reset asserted mid-instruction wins over any transition. Any pending memory request is dropped next cycle.
- Cycle counts with `mem_ready` held high:
  - R-type, I-type, LUI: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - JAL/JALR: 3 cycles.
- Each cycle with `mem_ready` low in FETCH/MEM_RD/MEM_WR adds exactly one cycle. Request outputs stay stable during the wait.
- `mem_ready` high outside a request state is ignored.
- `func_op` and `aluop` are valid for the full EXEC/BRANCH/MEM_ADDR cycle.

## Configuration
- `MAIN_CTRL_JUMP_EN` defined: JAL/JALR decode to JUMP.
  - JUMP asserts `reg_write`=1, `wb_sel`=10, `pc_write`=1, `pc_src`=1, `aluop`=00.
  - `alu_src_a`=0 for JAL, 1 for JALR; `alu_src_b`=01.
  - Then FETCH.
- Undefined: opcodes 1101111/1100111 go to TRAP, and the JUMP state is absent from the RTL.

## Structure
- Shared package holds:
  - Opcode constants.
  - State enum typedef.
  - `aluop` encodings (00/01/10/11).
  - `alu_src_b` and `wb_sel` encodings.
- One sub-module, `opcode_legal_check`, is natural: combinational legality check of opcode/funct3/funct7.
- Next-state and output decode stay in the top module.

## Test plan
- `add x1,x2,x3` (0x003100B3), `mem_ready`=1 → states FETCH, DECODE, EXEC_R, WB_ALU; in EXEC_R `aluop`=10, `func_op`=0000; `reg_write` in cycle 4.
- `sub` (0x403100B3) → `func_op`=1000 in EXEC_R.
- `srai x1,x2,3` (0x40315093) → `aluop`=11, `func_op`=1101.
- `lui x1,0x12345` → `lui`=1 and `aluop`=00 in EXEC_LUI; `wb_sel`=00.
- `lw` with `mem_ready` low for 3 cycles in MEM_RD → total 8 cycles; `mem_read` held steady; `wb_sel`=01 in WB_MEM.
- `beq` with `alu_zero`=1 → `pc_write`=1, `pc_src`=1 in cycle 3; with `alu_zero`=0 → `pc_write`=0.
- Opcode 0x7F → TRAP, `illegal`=1 stays set; `rst` pulse in TRAP → FETCH, `illegal`=0.
- `jal` with the macro undefined → TRAP; with it defined → `wb_sel`=10, `pc_src`=1 in cycle 3.

Source files
------------

// File: rtl/main_control_fsm_pkg.sv
// Shared constants for the RV32I multi-cycle main control: opcodes, FSM states, mux encodings.
// The JUMP state exists only when MAIN_CTRL_JUMP_EN is defined.
package main_control_fsm_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] WBSEL_ALU = 2'b00;
    localparam logic [1:0] WBSEL_MEM = 2'b01;
    localparam logic [1:0] WBSEL_PC4 = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_EXEC_LUI,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_ALU,
        S_WB_MEM,
        S_BRANCH,
`ifdef MAIN_CTRL_JUMP_EN
        S_JUMP,
`endif
        S_TRAP
    } state_t;

endpackage

// File: rtl/main_control_fsm_if.sv
// Control bundle between the main control FSM (master) and the datapath/memory (slave).
interface main_control_fsm_if;
    logic [31:0] instr;
    logic        mem_ready;
    logic        alu_zero;
    logic [1:0]  aluop;
    logic [3:0]  func_op;
    logic        lui;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        pc_write;
    logic        reg_write;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  wb_sel;
    logic        pc_src;
    logic        illegal;

    modport master (
        input  instr, mem_ready, alu_zero,
        output aluop, func_op, lui, mem_read, mem_write, ir_write, pc_write,
               reg_write, alu_src_a, alu_src_b, wb_sel, pc_src, illegal
    );

    modport slave (
        output instr, mem_ready, alu_zero,
        input  aluop, func_op, lui, mem_read, mem_write, ir_write, pc_write,
               reg_write, alu_src_a, alu_src_b, wb_sel, pc_src, illegal
    );
endinterface

// File: rtl/main_control_fsm_opcode_legal_check.sv
// Purpose: combinational legality check of opcode and R-type funct7/funct3 (JAL/JALR legal only with MAIN_CTRL_JUMP_EN).
// Latency: zero cycles, pure combinational.
// Backpressure: none; no handshake.
module opcode_legal_check
    import main_control_fsm_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic       legal
);

    always_comb begin
        legal = 1'b0;
        case (opcode)
            // Only base ADD/SUB/SRL/SRA-class funct7 values are supported.
            OP_R: begin
                if (funct7 == 7'b0000000)
                    legal = 1'b1;
                else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))
                    legal = 1'b1;
            end
            OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI: legal = 1'b1;
`ifdef MAIN_CTRL_JUMP_EN
            OP_JAL, OP_JALR: legal = 1'b1;
`endif
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/main_control_fsm.sv
// Purpose: multi-cycle RV32I main control FSM; JAL/JALR support under MAIN_CTRL_JUMP_EN.
// Latency: 3-5 cycles per instruction with mem_ready high (load 5, ALU/LUI/store 4, branch/jump 3).
// Backpressure: FETCH/MEM_RD/MEM_WR hold their request stable until mem_ready; one extra cycle per low cycle.
module main_control_fsm (
    input  logic                clk,
    input  logic                rst,
    main_control_fsm_if.master  ctl
);
    import main_control_fsm_pkg::*;

    state_t      state;
    state_t      next_state;
    logic        illegal_q;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        legal;
    logic        br_legal;
    logic        br_taken;
    logic        unused_instr_bits;

    assign opcode   = ctl.instr[6:0];
    assign funct3   = ctl.instr[14:12];
    assign br_legal = (funct3 == 3'b000) || (funct3 == 3'b001);
    assign br_taken = ((funct3 == 3'b000) && ctl.alu_zero) ||
                      ((funct3 == 3'b001) && !ctl.alu_zero);
    assign unused_instr_bits = ^{ctl.instr[24:15], ctl.instr[11:7]};
    assign ctl.illegal = illegal_q;

    opcode_legal_check u_opcode_legal_check (
        .opcode (opcode),
        .funct3 (funct3),
        .funct7 (ctl.instr[31:25]),
        .legal  (legal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state == S_TRAP)
                illegal_q <= 1'b1;
        end
    end

    always_comb begin
        next_state    = state;
        ctl.aluop     = ALUOP_ADD;
        ctl.func_op   = 4'b0000;
        ctl.lui       = 1'b0;
        ctl.mem_read  = 1'b0;
        ctl.mem_write = 1'b0;
        ctl.ir_write  = 1'b0;
        ctl.pc_write  = 1'b0;
        ctl.reg_write = 1'b0;
        ctl.alu_src_a = 1'b0;
        ctl.alu_src_b = SRCB_RS2;
        ctl.wb_sel    = WBSEL_ALU;
        ctl.pc_src    = 1'b0;

        case (state)
            S_FETCH: begin
                ctl.mem_read = 1'b1;
                // No IR/PC update while reset is still held.
                ctl.ir_write = ctl.mem_ready && !rst;
                ctl.pc_write = ctl.mem_ready && !rst;
                if (ctl.mem_ready)
                    next_state = S_DECODE;
            end
            S_DECODE: begin
                if (!legal)
                    next_state = S_TRAP;
                else begin
                    case (opcode)
                        OP_R:              next_state = S_EXEC_R;
                        OP_I:              next_state = S_EXEC_I;
                        OP_LOAD, OP_STORE: next_state = S_MEM_ADDR;
                        OP_BRANCH:         next_state = S_BRANCH;
                        OP_LUI:            next_state = S_EXEC_LUI;
`ifdef MAIN_CTRL_JUMP_EN
                        OP_JAL, OP_JALR:   next_state = S_JUMP;
`endif
                        default:           next_state = S_TRAP;
                    endcase
                end
            end
            S_EXEC_R: begin
                ctl.aluop     = ALUOP_R;
                ctl.func_op   = {ctl.instr[30], funct3};
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_RS2;
                next_state    = S_WB_ALU;
            end
            S_EXEC_I: begin
                ctl.aluop     = ALUOP_I;
                ctl.func_op   = {ctl.instr[30], funct3};
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                next_state    = S_WB_ALU;
            end
            S_EXEC_LUI: begin
                ctl.aluop     = ALUOP_ADD;
                ctl.func_op   = {ctl.instr[30], funct3};
                ctl.lui       = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                next_state    = S_WB_ALU;
            end
            S_MEM_ADDR: begin
                ctl.aluop     = ALUOP_ADD;
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                next_state    = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                ctl.mem_read = 1'b1;
                if (ctl.mem_ready)
                    next_state = S_WB_MEM;
            end
            S_MEM_WR: begin
                ctl.mem_write = 1'b1;
                if (ctl.mem_ready)
                    next_state = S_FETCH;
            end
            S_WB_ALU: begin
                ctl.reg_write = 1'b1;
                ctl.wb_sel    = WBSEL_ALU;
                next_state    = S_FETCH;
            end
            S_WB_MEM: begin
                ctl.reg_write = 1'b1;
                ctl.wb_sel    = WBSEL_MEM;
                next_state    = S_FETCH;
            end
            S_BRANCH: begin
                ctl.aluop     = ALUOP_SUB;
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_RS2;
                ctl.pc_write  = br_legal && br_taken;
                ctl.pc_src    = br_legal && br_taken;
                next_state    = br_legal ? S_FETCH : S_TRAP;
            end
`ifdef MAIN_CTRL_JUMP_EN
            S_JUMP: begin
                ctl.aluop     = ALUOP_ADD;
                ctl.reg_write = 1'b1;
                ctl.wb_sel    = WBSEL_PC4;
                ctl.pc_write  = 1'b1;
                ctl.pc_src    = 1'b1;
                ctl.alu_src_a = (opcode == OP_JALR);
                ctl.alu_src_b = SRCB_IMM;
                next_state    = S_FETCH;
            end
`endif
            S_TRAP:  next_state = S_TRAP;
            default: next_state = S_FETCH;
        endcase
    end

endmodule
